// File: rtl/sprdma_pkg.sv
// Sprite DMA shared definitions: FSM state encodings and the bus addresses
// shared with the PPU register decode.
package sprdma_pkg;

  typedef enum logic [2:0] {
    ST_READY     = 3'd0,
    ST_ACTIVE_RD = 3'd1,
    ST_ACTIVE_WR = 3'd2,
    ST_COOLDOWN  = 3'd3,
    ST_ALIGN     = 3'd4
  } state_t;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/sprdma.sv
// Sprite DMA: on a CPU write to 4014 copies page {data,00..FF} into 2004, one byte per read/write cpu_ce pair.
// Optional SPRDMA_ALIGN_EN adds a one-cpu_ce ALIGN state before the first read.
module sprdma
  import sprdma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic [15:0] cpumc_a,
  input  logic [7:0]  cpumc_din,
  input  logic [7:0]  cpumc_dout_in,
  input  logic        cpumc_r_nw_in,
  output logic        active,
  output logic [15:0] cpumc_a_out,
  output logic [7:0]  cpumc_dout,
  output logic        cpumc_r_nw
);

  state_t      q_state, d_state;
  logic [7:0]  q_page, d_page;
  logic [7:0]  q_index, d_index;
  logic [7:0]  q_data, d_data;
  logic        q_active, d_active;
  logic [15:0] q_a_out, d_a_out;
  logic [7:0]  q_dout, d_dout;
  logic        q_r_nw, d_r_nw;
  logic        trig;

  assign trig = cpu_ce & ~cpumc_r_nw_in & (cpumc_a == DMA_TRIG_ADDR);

  always_comb begin
    d_state = q_state;
    d_page  = q_page;
    d_index = q_index;
    d_data  = q_data;
    if (cpu_ce) begin
      case (q_state)
        ST_READY: begin
          if (trig) begin
            d_page  = cpumc_dout_in;
            d_index = 8'h00;
`ifdef SPRDMA_ALIGN_EN
            d_state = ST_ALIGN;
`else
            d_state = ST_ACTIVE_RD;
`endif
          end
        end
`ifdef SPRDMA_ALIGN_EN
        ST_ALIGN:     d_state = ST_ACTIVE_RD;
`endif
        ST_ACTIVE_RD: begin
          d_data  = cpumc_din;
          d_state = ST_ACTIVE_WR;
        end
        ST_ACTIVE_WR: begin
          // index wraps in 8 bits; the page is never carried into
          d_index = q_index + 8'h01;
          d_state = (q_index == 8'hFF) ? ST_COOLDOWN : ST_ACTIVE_RD;
        end
        ST_COOLDOWN:  d_state = ST_READY;
        default:      d_state = ST_READY;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    d_active = 1'b1;
    d_a_out  = OAM_DATA_ADDR;
    d_dout   = 8'h00;
    d_r_nw   = 1'b1;
    case (d_state)
      ST_READY: begin
        d_active = 1'b0;
        d_a_out  = 16'h0000;
      end
      ST_ALIGN:     d_a_out = DMA_TRIG_ADDR;
      ST_ACTIVE_RD: d_a_out = {d_page, d_index};
      ST_ACTIVE_WR: begin
        d_dout = d_data;
        d_r_nw = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_state  <= ST_READY;
      q_page   <= 8'h00;
      q_index  <= 8'h00;
      q_data   <= 8'h00;
      q_active <= 1'b0;
      q_a_out  <= 16'h0000;
      q_dout   <= 8'h00;
      q_r_nw   <= 1'b1;
    end else begin
      q_state  <= d_state;
      q_page   <= d_page;
      q_index  <= d_index;
      q_data   <= d_data;
      q_active <= d_active;
      q_a_out  <= d_a_out;
      q_dout   <= d_dout;
      q_r_nw   <= d_r_nw;
    end
  end

  assign active      = q_active;
  assign cpumc_a_out = q_a_out;
  assign cpumc_dout  = q_dout;
  assign cpumc_r_nw  = q_r_nw;

endmodule

// File: tb/tb_sprdma.sv
// Scoreboard bench for sprdma: expected reads/writes queued at trigger, checked by a negedge monitor.
module tb_sprdma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic [15:0] cpumc_a;
  logic [7:0]  cpumc_din;
  logic [7:0]  cpumc_dout_in;
  logic        cpumc_r_nw_in;
  logic        active;
  logic [15:0] cpumc_a_out;
  logic [7:0]  cpumc_dout;
  logic        cpumc_r_nw;

  logic [7:0]  mem_xor;
  int          compared = 0;
  int          mismatched = 0;
  int          wr_cnt = 0;
  logic [7:0]  exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [25:0] snap;
  logic        prev_hold = 1'b0;

`ifdef SPRDMA_ALIGN_EN
  localparam int EXP_CE = 514;
  localparam int EXP_FIRST_RD = 2;
`else
  localparam int EXP_CE = 513;
  localparam int EXP_FIRST_RD = 1;
`endif

  always #10 clk = ~clk;

  // Memory model: byte at address = low address byte xor a per-test key.
  assign cpumc_din = (active ? cpumc_a_out[7:0] : cpumc_a[7:0]) ^ mem_xor;

  sprdma dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_ce        (cpu_ce),
    .cpumc_a       (cpumc_a),
    .cpumc_din     (cpumc_din),
    .cpumc_dout_in (cpumc_dout_in),
    .cpumc_r_nw_in (cpumc_r_nw_in),
    .active        (active),
    .cpumc_a_out   (cpumc_a_out),
    .cpumc_dout    (cpumc_dout),
    .cpumc_r_nw    (cpumc_r_nw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0h with no expected entry", name, act);
  endtask

  // Monitor: inputs are settled mid-cycle, so negedge shows what the next posedge consumes.
  always @(negedge clk) begin
    if (prev_hold)
      chk("hold_stable", 32'({active, cpumc_a_out, cpumc_dout, cpumc_r_nw}), 32'(snap));
    snap = {active, cpumc_a_out, cpumc_dout, cpumc_r_nw};
    prev_hold = !cpu_ce && !rst;
    if (!rst && cpu_ce && active) begin
      if (!cpumc_r_nw) begin
        chk("wr_addr", 32'(cpumc_a_out), 32'h2004);
        if (exp_wr_q.size() == 0) miss("unexpected_wr", 32'(cpumc_dout));
        else chk("wr_data", 32'(cpumc_dout), 32'(exp_wr_q.pop_front()));
        wr_cnt++;
      end else if (cpumc_a_out != 16'h2004 && cpumc_a_out != 16'h4014) begin
        if (exp_rd_q.size() == 0) miss("unexpected_rd", 32'(cpumc_a_out));
        else chk("rd_addr", 32'(cpumc_a_out), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cpu_ce        = 1'b0;
    cpumc_a       = 16'h0000;
    cpumc_r_nw_in = 1'b1;
    cpumc_dout_in = 8'h00;
  endtask

  task automatic pulse(input int gap, input bit with_trig);
    set_idle();
    repeat (gap) cyc();
    cpu_ce = 1'b1;
    if (with_trig) begin
      cpumc_a       = 16'h4014;
      cpumc_r_nw_in = 1'b0;
      cpumc_dout_in = 8'h05;
    end
    cyc();
    set_idle();
  endtask

  task automatic chk_ready(input string name);
    chk(name, 32'({active, cpumc_a_out, cpumc_dout, cpumc_r_nw}), 32'({1'b0, 16'h0000, 8'h00, 1'b1}));
  endtask

  task automatic run_xfer(input logic [7:0] pg, input int gap_mode, input int inject_at, input int rst_after);
    int n;
    int first_rd;
    int w0;
    int g;
    n = 0;
    first_rd = 0;
    w0 = wr_cnt;
    for (int i = 0; i < 256; i++) begin
      exp_rd_q.push_back({pg, 8'(i)});
      exp_wr_q.push_back(8'(i) ^ mem_xor);
    end
    cpu_ce        = 1'b1;
    cpumc_a       = 16'h4014;
    cpumc_r_nw_in = 1'b0;
    cpumc_dout_in = pg;
    cyc();
    set_idle();
    chk("active_rise", 32'(active), 32'h1);
    while (active && n < 700) begin
      if (rst_after > 0 && wr_cnt - w0 == rst_after) begin
        rst    = 1'b1;
        cpu_ce = 1'b1;
        cyc();
        chk_ready("rst_mid_out");
        rst = 1'b0;
        set_idle();
        exp_wr_q.delete();
        exp_rd_q.delete();
        repeat (40) pulse(1, 1'b0);
        chk("post_rst_wr", 32'(wr_cnt - w0), 32'(rst_after));
        chk_ready("post_rst_idle");
        return;
      end
      if (first_rd == 0 && cpumc_r_nw && cpumc_a_out != 16'h2004 && cpumc_a_out != 16'h4014)
        first_rd = n + 1;
      g = (gap_mode < 0) ? int'($urandom_range(0, 7)) : gap_mode;
      pulse(g, n == inject_at);
      n++;
    end
    chk("ce_count", 32'(n), 32'(EXP_CE));
    chk("first_rd", 32'(first_rd), 32'(EXP_FIRST_RD));
    chk("wr_count", 32'(wr_cnt - w0), 32'd256);
    chk("queue_drained", 32'(exp_wr_q.size() + exp_rd_q.size()), 32'd0);
    chk_ready("done_out");
  endtask

  initial begin
    rst     = 1'b1;
    mem_xor = 8'hA5;
    set_idle();
    repeat (3) cyc();
    chk_ready("reset_out");
    rst = 1'b0;
    cyc();
    chk_ready("idle_out");

    run_xfer(8'h02, 3, -1, 0);     // cpu_ce every 4 clk
    mem_xor = 8'h00;
    run_xfer(8'hFF, 0, -1, 0);     // top page, data equals low address byte
    mem_xor = 8'hA5;
    run_xfer(8'h37, 1, -1, 100);   // reset after 100 bytes
    run_xfer(8'h10, 2, 50, 0);     // retrigger mid-transfer is ignored
    run_xfer(8'h02, -1, -1, 0);    // random 0-7 clk gaps

    // Reset wins over a simultaneous trigger.
    rst           = 1'b1;
    cpu_ce        = 1'b1;
    cpumc_a       = 16'h4014;
    cpumc_r_nw_in = 1'b0;
    cpumc_dout_in = 8'h02;
    cyc();
    rst = 1'b0;
    set_idle();
    chk_ready("rst_vs_trig");
    // Trigger bus values without cpu_ce do nothing.
    cpumc_a       = 16'h4014;
    cpumc_r_nw_in = 1'b0;
    cyc();
    set_idle();
    cyc();
    chk_ready("trig_no_ce");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprdma.md
SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 clk  input  1  50 MHz system clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 cpu_ce  input  1  one-clk pulse per CPU cycle; the FSM advances only on clk edges where cpu_ce=1.
REQ-004 cpumc_a  input  16  CPU-issued memory address (valid while CPU owns the bus).
REQ-005 cpumc_din  input  8  data returned by CPU memory map for the current address.
REQ-006 cpumc_dout_in  input  8  CPU-issued write data.
REQ-007 cpumc_r_nw_in  input  1  CPU-issued read(1)/write(0).
REQ-008 active  output  1  1 = DMA owns the CPU bus; CPU SHALL be held while high.
REQ-009 cpumc_a_out  output  16  DMA-driven address, valid while active=1.
REQ-010 cpumc_dout  output  8  DMA write data, valid while active=1.
REQ-011 cpumc_r_nw  output  1  DMA read(1)/write(0), valid while active=1.

Function
REQ-012 States: READY, ACTIVE_RD, ACTIVE_WR, COOLDOWN; reset state READY.
REQ-013 Trigger: in READY, cpu_ce=1 & cpumc_r_nw_in=0 & cpumc_a=16'h4014 SHALL latch page=cpumc_dout_in[7:0], byte index=8'h00, and go to ACTIVE_RD (or ALIGN, REQ-025).
REQ-014 Triggers seen outside READY SHALL be ignored.
REQ-015 ACTIVE_RD: drive cpumc_a_out={page,index}, cpumc_r_nw=1; on cpu_ce latch cpumc_din into data register, go ACTIVE_WR.
REQ-016 ACTIVE_WR: drive cpumc_a_out=16'h2004, cpumc_dout=data register, cpumc_r_nw=0; on cpu_ce increment index (8-bit) and go ACTIVE_RD, unless index was 8'hFF, then go COOLDOWN.
REQ-017 Index wraps within 8 bits only; page never increments (page FF reads FF00-FFFF).
REQ-018 COOLDOWN: active=1, cpumc_r_nw=1, cpumc_a_out=16'h2004; on cpu_ce go READY.
REQ-019 active SHALL be 1 in every state except READY, asserted from the clk edge after the trigger.
REQ-020 Transfer length: exactly 256 reads and 256 writes; 513 cpu_ce pulses from trigger to READY (514 with SPRDMA_ALIGN_EN).
REQ-021 In READY: active=0, cpumc_a_out=16'h0000, cpumc_dout=8'h00, cpumc_r_nw=1.
REQ-022 cpu_ce=0 cycles SHALL hold all state and outputs unchanged (arbitrary stalls allowed).

Reset
REQ-023 rst=1 SHALL force READY, page=8'h00, index=8'h00, data=8'h00 and the REQ-021 output values on the next clk edge, including mid-transfer; no further write to 16'h2004 SHALL occur.
REQ-024 rst SHALL take priority over cpu_ce and trigger in the same cycle.

Configuration
REQ-025 Macro SPRDMA_ALIGN_EN defined: extra state ALIGN entered on trigger; drives cpumc_a_out=16'h4014, cpumc_r_nw=1, active=1; on cpu_ce go ACTIVE_RD. Undefined: ALIGN absent, trigger goes directly to ACTIVE_RD.

Structure
REQ-026 Shared package/include SHALL hold the state encodings, 16'h4014 (DMA trigger addr) and 16'h2004 (OAM data addr), shared with the ppu register decode.
REQ-027 No sub-module; single FSM plus page/index/data registers, q_/d_ register split.

Verification
REQ-028 Write 8'h02 to 16'h4014 with cpu_ce every 4 clk -> active rises next clk; 256 writes to 16'h2004 carry bytes of 0200-02FF in order; active falls after 513th cpu_ce.
REQ-029 Page 8'hFF, memory model returns low address byte -> write data sequence 00..FF; no address above FFFF or page change.
REQ-030 rst asserted after 100 bytes transferred -> next clk active=0, outputs at REQ-021 values; no further 16'h2004 writes.
REQ-031 Second write to 16'h4014 during transfer -> ignored; total count remains 256.
REQ-032 Random cpu_ce gaps (0-7 clk) -> identical write sequence, outputs stable between pulses.
REQ-033 With SPRDMA_ALIGN_EN -> first read at 2nd cpu_ce after trigger; completion at 514 cpu_ce.
